// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM-stage access unit and the memory.
// Request fields are held stable while mem_req_valid waits for mem_req_ready.
interface mem_access_unit_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: store lane formatting, alignment check,
// valid/ready request plus read response, pipeline stall and optional timeout abort.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        HoldM,
  output logic        StallM,
  output logic [31:0] RD_data,
  output logic [1:0]  byteAddrM,
  output logic        misalignedM,
  output logic        bus_errM,
  mem_access_unit_if.master mem
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT_R = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  logic [1:0]  state_reg, state_next;
  logic [31:0] to_cnt_reg;
  logic        we_reg;
  logic [31:0] addr_reg, wdata_reg, rd_data_reg;
  logic [3:0]  wstrb_reg;
  logic [1:0]  byte_addr_reg;
  logic        bus_err_reg;

  logic        access, start, busy;
  logic        both_bad, load_bad, store_bad, half_mis, word_mis;
  logic [31:0] wdata_fmt;
  logic [3:0]  wstrb_fmt;
  logic        timeout_hit, timeout_abort;

  assign access = MemReadM | MemWriteM;

  always_comb begin
    both_bad    = MemReadM & MemWriteM;
    load_bad    = MemReadM & !(funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    store_bad   = MemWriteM & !(funct3M inside {3'b000, 3'b001, 3'b010});
    half_mis    = (funct3M[1:0] == 2'b01) & ALUResultM[0];
    word_mis    = (funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00);
    misalignedM = access & (both_bad | load_bad | store_bad | half_mis | word_mis);
  end

  // reset_n gates the launch so StallM drops the moment reset is asserted
  assign start = (state_reg == S_IDLE) & access & ~misalignedM & reset_n;
  assign busy  = (state_reg == S_REQ) | (state_reg == S_WAIT_R);
  assign StallM = start | busy;

  always_comb begin
    wdata_fmt = WriteDataM;
    wstrb_fmt = 4'b1111;
    case (funct3M[1:0])
      2'b00: begin
        wdata_fmt = {4{WriteDataM[7:0]}};
        wstrb_fmt = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        wdata_fmt = {2{WriteDataM[15:0]}};
        wstrb_fmt = ALUResultM[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!MemWriteM) wstrb_fmt = 4'b0000;
  end

  assign timeout_hit   = (TIMEOUT_CYCLES != 0) && busy && (to_cnt_reg == TO_LAST);
  // a handshake landing in the timeout cycle takes priority over the abort
  assign timeout_abort = timeout_hit &
                         (((state_reg == S_REQ) & ~mem.mem_req_ready) |
                          ((state_reg == S_WAIT_R) & ~mem.mem_rvalid));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_REQ;
      S_REQ: begin
        if (mem.mem_req_ready) state_next = we_reg ? S_DONE : S_WAIT_R;
        else if (timeout_hit)  state_next = S_DONE;
      end
      S_WAIT_R: if (mem.mem_rvalid || timeout_hit) state_next = S_DONE;
      S_DONE:   if (!HoldM) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      to_cnt_reg    <= 32'd0;
      we_reg        <= 1'b0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      wstrb_reg     <= 4'b0000;
      byte_addr_reg <= 2'b00;
      rd_data_reg   <= 32'd0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bus_err_reg <= timeout_abort;
      if (state_next == S_IDLE) to_cnt_reg <= 32'd0;
      else if (busy)            to_cnt_reg <= to_cnt_reg + 32'd1;
      if (start) begin
        we_reg        <= MemWriteM;
        addr_reg      <= {ALUResultM[31:2], 2'b00};
        wdata_reg     <= wdata_fmt;
        wstrb_reg     <= wstrb_fmt;
        byte_addr_reg <= ALUResultM[1:0];
      end
      if ((state_reg == S_WAIT_R) && mem.mem_rvalid) rd_data_reg <= mem.mem_rdata;
      else if (timeout_abort)                        rd_data_reg <= 32'd0;
    end
  end

  assign mem.mem_req_valid = (state_reg == S_REQ);
  assign mem.mem_we        = we_reg;
  assign mem.mem_addr      = addr_reg;
  assign mem.mem_wdata     = wdata_reg;
  assign mem.mem_wstrb     = wstrb_reg;
  assign RD_data           = rd_data_reg;
  assign byteAddrM         = byte_addr_reg;
  assign bus_errM          = bus_err_reg;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access controller, directly upstream of the load-extension unit.
- Formats stores (byte-lane replication plus write strobes), checks alignment, and runs a valid/ready request plus read-response handshake to a variable-latency data memory.
- Stalls the pipeline until the access completes.
- Presents the raw 32-bit read word and the byte offset so the load-extension unit can select and extend the loaded value.

Parameters:
- TIMEOUT_CYCLES, 0: maximum cycles spent in REQ plus WAIT_R before the access is aborted with bus_err_M; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- MemReadM  in  1  load instruction in MEM.
- MemWriteM  in  1  store instruction in MEM.
- funct3M  in  3  load/store type (000 b, 001 h, 010 w, 100 bu, 101 hu).
- ALUResultM  in  32  effective byte address.
- WriteDataM  in  32  store source register value.
- HoldM  in  1  pipeline held by another hazard; MEM instruction does not advance this cycle.
- StallM  out  1  access in progress; freeze F/D/E/M.
- RD_data  out  32  registered raw word read from memory.
- byteAddrM  out  2  registered ALUResultM[1:0] of the completed access.
- misalignedM  out  1  combinational alignment/illegal-type fault.
- bus_errM  out  1  one-cycle pulse on timeout abort.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-formatted store data.
- mem_wstrb  out  4  byte write strobes; 0000 on reads.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (asynchronous, reset_n=0) forces immediately:
  - state=IDLE;
  - StallM, mem_req_valid, mem_we, bus_errM = 0;
  - mem_addr, mem_wdata, RD_data = 0;
  - mem_wstrb=0; byteAddrM=0; timeout counter=0.
  - Reset mid-transaction abandons the access and drops mem_req_valid at once; late mem_rvalid after reset is ignored.
- Fault check (combinational, sets misalignedM=1):
  - MemReadM and MemWriteM both 1;
  - load funct3 not in {000,001,010,100,101};
  - store funct3 not in {000,001,010};
  - h/hu with addr[0]=1;
  - w with addr[1:0]!=00.
  - A faulting access issues no request and does not stall. misalignedM is qualified by MemReadM|MemWriteM and is 0 otherwise.
- Store formatting:
  - sb: wdata={4{WriteDataM[7:0]}}, wstrb=0001<<addr[1:0].
  - sh: wdata={2{WriteDataM[15:0]}}, wstrb=addr[1]?1100:0011.
  - sw: wdata=WriteDataM, wstrb=1111.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - On a valid non-faulting access, latch addr, wdata, wstrb, we, and byteAddrM; go to REQ.
  - StallM=1 combinationally in that same cycle.
- REQ:
  - mem_req_valid=1; request fields stay stable until the handshake.
  - On mem_req_ready=1: go to DONE if write, WAIT_R if read.
  - StallM=1.
- WAIT_R:
  - On mem_rvalid=1, capture RD_data<=mem_rdata and go to DONE.
  - StallM=1.
  - A mem_rvalid arriving in the same cycle as the request handshake is not accepted; memory responds no earlier than the cycle after acceptance.
- DONE:
  - StallM=0; RD_data and byteAddrM are valid for the load-extension unit.
  - If HoldM=1, stay in DONE: no re-issue, outputs held.
  - Otherwise go to IDLE.
- Minimum latency:
  - store: 2 stall cycles (IDLE, REQ with ready=1);
  - load: 3 stall cycles (rvalid the cycle after acceptance).
- Timeout (TIMEOUT_CYCLES>0):
  - The counter increments each cycle in REQ or WAIT_R and clears on entering IDLE.
  - On reaching TIMEOUT_CYCLES: drop mem_req_valid, set RD_data=0, pulse bus_errM for one cycle, and go to DONE.
  - A handshake in the timeout cycle wins over the timeout.
- RD_data holds its value between loads; stores do not modify it.

Test Plan:
- lw addr 0x100, ready=1 immediately, rvalid one cycle later with 0xDEADBEEF -> StallM high 3 cycles; DONE shows RD_data=0xDEADBEEF, byteAddrM=00; mem_addr=0x100, mem_wstrb=0000.
- sb addr 0x203, WriteDataM=0x123456AB -> mem_addr=0x200, mem_wdata=0xABABABAB, mem_wstrb=1000, mem_we=1; StallM 2 cycles; RD_data unchanged.
- sh addr 0x302, ready delayed 3 cycles -> mem_wstrb=1100, mem_wdata=0x56AB56AB; req fields stable across wait; StallM 5 cycles.
- lw addr 0x101; lh addr 0x103; store funct3=100 -> misalignedM=1, mem_req_valid never asserts, StallM=0.
- TIMEOUT_CYCLES=4, lw with mem_rvalid never asserting -> bus_errM pulses once, RD_data=0, returns to IDLE; reset_n pulsed low during WAIT_R -> mem_req_valid=0 and StallM=0 immediately.
- HoldM=1 for 2 cycles in DONE after sw -> exactly one bus write; StallM=0 throughout the hold.
